// File: rtl/pipeline_hazard_ctrl_if.sv
// Control bundle between the hazard sequencer and the core pipeline/DRAM port.
// master: the sequencer; slave: the pipeline and memory side.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       rs1_id_i;
    logic [4:0]       rs2_id_i;
    logic             rs1_used_id_i;
    logic             rs2_used_id_i;
    logic [4:0]       wr_ex_i;
    logic             rf_we_ex_i;
    logic [1:0]       wd_sel_ex_i;
    logic             branch_taken_ex_i;
    logic             mem_req_mem_i;
    logic             dram_ready_i;
    logic             dram_req_o;
    logic             stall_if_o;
    logic             stall_id_o;
    logic             stall_ex_o;
    logic             flush_id_o;
    logic             flush_ex_o;
    logic             bubble_wb_o;
    logic             mem_timeout_o;
    logic [CNT_W-1:0] stall_cnt_o;

    modport master (
        input  rs1_id_i, rs2_id_i, rs1_used_id_i, rs2_used_id_i,
        input  wr_ex_i, rf_we_ex_i, wd_sel_ex_i, branch_taken_ex_i,
        input  mem_req_mem_i, dram_ready_i,
        output dram_req_o, stall_if_o, stall_id_o, stall_ex_o,
        output flush_id_o, flush_ex_o, bubble_wb_o, mem_timeout_o, stall_cnt_o
    );

    modport slave (
        output rs1_id_i, rs2_id_i, rs1_used_id_i, rs2_used_id_i,
        output wr_ex_i, rf_we_ex_i, wd_sel_ex_i, branch_taken_ex_i,
        output mem_req_mem_i, dram_ready_i,
        input  dram_req_o, stall_if_o, stall_id_o, stall_ex_o,
        input  flush_id_o, flush_ex_o, bubble_wb_o, mem_timeout_o, stall_cnt_o
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage core: load-use and branch hazards plus
// the MEM-stage DRAM wait handshake with timeout abort.
module pipeline_hazard_ctrl #(
    parameter int         MEM_TIMEOUT = 16,
    parameter logic [1:0] WD_SEL_DRAM = 2'b01,
    parameter int         CNT_W       = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pipeline_hazard_ctrl_if.master bus
);
    localparam int              WC_W   = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [WC_W-1:0] WC_MAX = WC_W'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ABORT    = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [WC_W-1:0] wcnt, wcnt_nxt;
    logic            timeout_set;
    logic            load_use;
    logic            mem_stall;
    logic            dram_req;
    logic            stall_if, stall_id, stall_ex;
    logic            flush_id, flush_ex, bubble_wb;
    logic            mem_timeout;
    logic [CNT_W-1:0] stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            wcnt        <= '0;
            mem_timeout <= 1'b0;
            stall_cnt   <= '0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
            if (timeout_set)
                mem_timeout <= 1'b1;
            if (stall_if && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        state_nxt   = state;
        wcnt_nxt    = wcnt;
        timeout_set = 1'b0;
        dram_req    = 1'b0;
        stall_if    = 1'b0;
        stall_id    = 1'b0;
        stall_ex    = 1'b0;
        flush_id    = 1'b0;
        flush_ex    = 1'b0;
        bubble_wb   = 1'b0;

        load_use = bus.rf_we_ex_i && (bus.wd_sel_ex_i == WD_SEL_DRAM) && (bus.wr_ex_i != 5'd0) &&
                   ((bus.rs1_used_id_i && (bus.rs1_id_i == bus.wr_ex_i)) ||
                    (bus.rs2_used_id_i && (bus.rs2_id_i == bus.wr_ex_i)));

        case (state)
            RUN:      dram_req = bus.mem_req_mem_i;
            MEM_WAIT: dram_req = 1'b1;
            default:  dram_req = 1'b0;
        endcase
        mem_stall = dram_req && !bus.dram_ready_i;

        // A memory freeze holds any pending branch/load-use until release.
        if (mem_stall) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            stall_ex  = 1'b1;
            bubble_wb = 1'b1;
        end else if (bus.branch_taken_ex_i) begin
            flush_id = 1'b1;
            flush_ex = 1'b1;
        end else if (load_use) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
            flush_ex = 1'b1;
        end
        if (state == ABORT)
            bubble_wb = 1'b1;

        case (state)
            RUN: begin
                if (bus.mem_req_mem_i && !bus.dram_ready_i) begin
                    state_nxt = MEM_WAIT;
                    wcnt_nxt  = WC_W'(1);
                end
            end
            MEM_WAIT: begin
                if (bus.dram_ready_i) begin
                    state_nxt = RUN;
                    wcnt_nxt  = '0;
                end else if (wcnt == WC_MAX) begin
                    state_nxt   = ABORT;
                    wcnt_nxt    = '0;
                    timeout_set = 1'b1;
                end else begin
                    wcnt_nxt = wcnt + WC_W'(1);
                end
            end
            default: begin
                state_nxt = RUN;
                wcnt_nxt  = '0;
            end
        endcase

        if (!rst_n) begin
            dram_req  = 1'b0;
            stall_if  = 1'b0;
            stall_id  = 1'b0;
            stall_ex  = 1'b0;
            flush_id  = 1'b0;
            flush_ex  = 1'b0;
            bubble_wb = 1'b0;
        end
    end

    assign bus.dram_req_o    = dram_req;
    assign bus.stall_if_o    = stall_if;
    assign bus.stall_id_o    = stall_id;
    assign bus.stall_ex_o    = stall_ex;
    assign bus.flush_id_o    = flush_id;
    assign bus.flush_ex_o    = flush_ex;
    assign bus.bubble_wb_o   = bubble_wb;
    assign bus.mem_timeout_o = mem_timeout;
    assign bus.stall_cnt_o   = stall_cnt;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: reference model feeds a scoreboard queue,
// each scenario task pops and compares, plus hand-computed spot checks.
module tb_pipeline_hazard_ctrl;
    localparam int TO = 4;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.CNT_W(CW)) bus();

    pipeline_hazard_ctrl #(
        .MEM_TIMEOUT(TO),
        .WD_SEL_DRAM(2'b01),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    // {dram_req, stall_if, stall_id, stall_ex, flush_id, flush_ex, bubble_wb, mem_timeout, stall_cnt}
    typedef logic [7+CW:0] obs_t;
    obs_t sb_q[$];
    obs_t e;
    int n_chk = 0;
    int n_pass = 0;

    int m_st;
    int m_wc;
    bit m_to;
    int m_cnt;

    task automatic model_reset();
        m_st = 0; m_wc = 0; m_to = 1'b0; m_cnt = 0;
    endtask

    function automatic obs_t model_out();
        bit req, ms, lu, sif, sid, sex, fid, fex, bwb;
        req = 0; ms = 0; lu = 0; sif = 0; sid = 0; sex = 0; fid = 0; fex = 0; bwb = 0;
        if (rst_n) begin
            if (m_st == 0) req = bus.mem_req_mem_i;
            else if (m_st == 1) req = 1'b1;
            ms = req && !bus.dram_ready_i;
            lu = bus.rf_we_ex_i && (bus.wd_sel_ex_i == 2'b01) && (bus.wr_ex_i != 5'd0) &&
                 ((bus.rs1_used_id_i && bus.rs1_id_i == bus.wr_ex_i) ||
                  (bus.rs2_used_id_i && bus.rs2_id_i == bus.wr_ex_i));
            if (ms) begin
                sif = 1; sid = 1; sex = 1; bwb = 1;
            end else if (bus.branch_taken_ex_i) begin
                fid = 1; fex = 1;
            end else if (lu) begin
                sif = 1; sid = 1; fex = 1;
            end
            if (m_st == 2) bwb = 1;
        end
        return {req, sif, sid, sex, fid, fex, bwb, m_to, CW'(m_cnt)};
    endfunction

    function automatic obs_t observe();
        return {bus.dram_req_o, bus.stall_if_o, bus.stall_id_o, bus.stall_ex_o, bus.flush_id_o,
                bus.flush_ex_o, bus.bubble_wb_o, bus.mem_timeout_o, bus.stall_cnt_o};
    endfunction

    task automatic drive(input bit rst, input bit mreq, input bit rdy, input bit br,
                         input bit we, input logic [1:0] ws, input logic [4:0] wr,
                         input bit u1, input logic [4:0] r1, input bit u2, input logic [4:0] r2);
        rst_n                 = rst;
        bus.mem_req_mem_i     = mreq;
        bus.dram_ready_i      = rdy;
        bus.branch_taken_ex_i = br;
        bus.rf_we_ex_i        = we;
        bus.wd_sel_ex_i       = ws;
        bus.wr_ex_i           = wr;
        bus.rs1_used_id_i     = u1;
        bus.rs1_id_i          = r1;
        bus.rs2_used_id_i     = u2;
        bus.rs2_id_i          = r2;
        if (!rst) model_reset();
        sb_q.push_back(model_out());
        #1;
    endtask

    task automatic tick();
        obs_t o;
        o = model_out();
        if (rst_n) begin
            if (o[6+CW] && m_cnt < (1 << CW) - 1) m_cnt++;
            case (m_st)
                0: if (bus.mem_req_mem_i && !bus.dram_ready_i) begin m_st = 1; m_wc = 1; end
                1: begin
                    if (bus.dram_ready_i) begin m_st = 0; m_wc = 0; end
                    else if (m_wc == TO) begin m_st = 2; m_wc = 0; m_to = 1'b1; end
                    else m_wc++;
                end
                default: m_st = 0;
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(0, 1, 0, 1, 1, 2'b01, 5'd5, 1, 5'd5, 0, 5'd0);
        e = sb_q.pop_front(); n_chk++;
        if (observe() !== e) $display("FAIL reset_sb: got %b want %b", observe(), e); else n_pass++;
        n_chk++;
        if (observe() !== '0) $display("FAIL reset_zero: got %b want 0", observe()); else n_pass++;
        tick();
        drive(1, 0, 0, 0, 0, 2'b00, 5'd0, 0, 5'd0, 0, 5'd0);
        e = sb_q.pop_front(); n_chk++;
        if (observe() !== e) $display("FAIL reset_idle: got %b want %b", observe(), e); else n_pass++;
        tick();
    endtask

    task automatic test_load_use();
        drive(1, 0, 0, 0, 1, 2'b01, 5'd5, 1, 5'd5, 0, 5'd0);
        e = sb_q.pop_front(); n_chk++;
        if (observe() !== e) $display("FAIL load_use_stall: got %b want %b", observe(), e); else n_pass++;
        n_chk++;
        if ({bus.stall_if_o, bus.stall_id_o, bus.flush_ex_o, bus.flush_id_o} !== 4'b1110)
            $display("FAIL load_use_ctl: got %b want 1110",
                     {bus.stall_if_o, bus.stall_id_o, bus.flush_ex_o, bus.flush_id_o});
        else n_pass++;
        tick();
        // load now in MEM, zero-wait access
        drive(1, 1, 1, 0, 0, 2'b00, 5'd0, 1, 5'd5, 0, 5'd0);
        e = sb_q.pop_front(); n_chk++;
        if (observe() !== e) $display("FAIL load_use_next: got %b want %b", observe(), e); else n_pass++;
        n_chk++;
        if (bus.stall_cnt_o !== CW'(1)) $display("FAIL load_use_cnt: got %0d want 1", bus.stall_cnt_o);
        else n_pass++;
        tick();
    endtask

    task automatic test_no_hazard();
        logic [4:0] wr_t [5] = '{5'd0, 5'd7, 5'd9, 5'd3, 5'd4};
        bit         u1_t [5] = '{1, 0, 0, 1, 1};
        bit         u2_t [5] = '{0, 0, 1, 0, 0};
        logic [1:0] ws_t [5] = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b01};
        bit         we_t [5] = '{1, 1, 1, 1, 0};
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 0, 0, we_t[i], ws_t[i], wr_t[i], u1_t[i], wr_t[i], u2_t[i], 5'd9);
            e = sb_q.pop_front(); n_chk++;
            if (observe() !== e) $display("FAIL no_hazard[%0d]: got %b want %b", i, observe(), e);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_branch_priority();
        drive(1, 0, 0, 1, 1, 2'b01, 5'd5, 1, 5'd5, 0, 5'd0);
        e = sb_q.pop_front(); n_chk++;
        if (observe() !== e) $display("FAIL branch_sb: got %b want %b", observe(), e); else n_pass++;
        n_chk++;
        if ({bus.flush_id_o, bus.flush_ex_o, bus.stall_if_o} !== 3'b110)
            $display("FAIL branch_ctl: got %b want 110", {bus.flush_id_o, bus.flush_ex_o, bus.stall_if_o});
        else n_pass++;
        tick();
        n_chk++;
        if (bus.stall_cnt_o !== CW'(2)) $display("FAIL branch_cnt: got %0d want 2", bus.stall_cnt_o);
        else n_pass++;
    endtask

    task automatic test_mem_wait();
        int n_req = 0;
        int n_stall = 0;
        for (int i = 0; i < 5; i++) begin
            drive(1, i < 4, i == 3, 0, 0, 2'b00, 5'd0, 0, 5'd0, 0, 5'd0);
            e = sb_q.pop_front(); n_chk++;
            if (observe() !== e) $display("FAIL mem_wait[%0d]: got %b want %b", i, observe(), e);
            else n_pass++;
            n_req += int'(bus.dram_req_o);
            n_stall += int'(bus.stall_if_o && bus.stall_id_o && bus.stall_ex_o && bus.bubble_wb_o);
            tick();
        end
        n_chk++;
        if (n_req != 4 || n_stall != 3)
            $display("FAIL mem_wait_len: got req=%0d stall=%0d want req=4 stall=3", n_req, n_stall);
        else n_pass++;
        n_chk++;
        if (bus.stall_cnt_o !== CW'(5)) $display("FAIL mem_wait_cnt: got %0d want 5", bus.stall_cnt_o);
        else n_pass++;
    endtask

    task automatic test_branch_held();
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, i == 2, 1, 0, 2'b00, 5'd0, 0, 5'd0, 0, 5'd0);
            e = sb_q.pop_front(); n_chk++;
            if (observe() !== e) $display("FAIL branch_held[%0d]: got %b want %b", i, observe(), e);
            else n_pass++;
            n_chk++;
            if ({bus.flush_id_o, bus.flush_ex_o, bus.stall_if_o} !== ((i == 2) ? 3'b110 : 3'b001))
                $display("FAIL branch_held_ctl[%0d]: got %b", i,
                         {bus.flush_id_o, bus.flush_ex_o, bus.stall_if_o});
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 8; i++) begin
            drive(1, i < 6, 0, 0, 0, 2'b00, 5'd0, 0, 5'd0, 0, 5'd0);
            e = sb_q.pop_front(); n_chk++;
            if (observe() !== e) $display("FAIL timeout[%0d]: got %b want %b", i, observe(), e);
            else n_pass++;
            if (i == 5) begin
                n_chk++;
                if ({bus.dram_req_o, bus.bubble_wb_o, bus.stall_if_o, bus.mem_timeout_o} !== 4'b0101)
                    $display("FAIL abort_ctl: got %b want 0101",
                             {bus.dram_req_o, bus.bubble_wb_o, bus.stall_if_o, bus.mem_timeout_o});
                else n_pass++;
            end
            tick();
        end
        n_chk++;
        if (bus.mem_timeout_o !== 1'b1 || bus.stall_cnt_o !== CW'(12))
            $display("FAIL timeout_sticky: got to=%b cnt=%0d want to=1 cnt=12", bus.mem_timeout_o, bus.stall_cnt_o);
        else n_pass++;
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, 0, 0, 0, 2'b00, 5'd0, 0, 5'd0, 0, 5'd0);
            e = sb_q.pop_front(); n_chk++;
            if (observe() !== e) $display("FAIL rewait[%0d]: got %b want %b", i, observe(), e);
            else n_pass++;
            tick();
        end
        drive(0, 1, 0, 1, 0, 2'b00, 5'd0, 0, 5'd0, 0, 5'd0);
        n_chk++;
        if (observe() !== '0) $display("FAIL reset_mid_wait: got %b want 0", observe()); else n_pass++;
        e = sb_q.pop_front();
        tick();
        drive(1, 0, 0, 0, 0, 2'b00, 5'd0, 0, 5'd0, 0, 5'd0);
        e = sb_q.pop_front(); n_chk++;
        if (observe() !== e) $display("FAIL after_reset: got %b want %b", observe(), e); else n_pass++;
        tick();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 18; i++) begin
            drive(1, 0, 0, 0, 1, 2'b01, 5'd12, 0, 5'd0, 1, 5'd12);
            e = sb_q.pop_front(); n_chk++;
            if (observe() !== e) $display("FAIL saturate[%0d]: got %b want %b", i, observe(), e);
            else n_pass++;
            tick();
        end
        n_chk++;
        if (bus.stall_cnt_o !== CW'(15)) $display("FAIL saturate_cnt: got %0d want 15", bus.stall_cnt_o);
        else n_pass++;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_load_use();
        test_no_hazard();
        test_branch_priority();
        test_mem_wait();
        test_branch_held();
        test_timeout();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage core.
- Drives hold and bubble controls for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Detects load-use hazards and taken-branch redirects.
- Runs the multi-cycle DRAM request/ready handshake for the MEM stage, freezing the pipeline while memory is busy, and aborts with a sticky error on timeout.

Parameters:
- MEM_TIMEOUT, 16: max MEM_WAIT cycles before abort, minimum 2.
- WD_SEL_DRAM, 2'b01: wd_sel encoding meaning "write-back from DRAM" (load).
- CNT_W, 32: width of the stall performance counter.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- rs1_id_i  in  5  rs1 of the instruction in ID
- rs2_id_i  in  5  rs2 of the instruction in ID
- rs1_used_id_i  in  1  ID instruction reads rs1
- rs2_used_id_i  in  1  ID instruction reads rs2
- wr_ex_i  in  5  destination register in EX
- rf_we_ex_i  in  1  EX instruction writes the register file
- wd_sel_ex_i  in  2  EX write-back source
- branch_taken_ex_i  in  1  EX resolved a taken branch or jump
- mem_req_mem_i  in  1  valid load/store in MEM
- dram_ready_i  in  1  DRAM completes the access this cycle
- dram_req_o  out  1  DRAM access request
- stall_if_o  out  1  hold PC and IF/ID
- stall_id_o  out  1  hold ID/EX
- stall_ex_o  out  1  hold EX/MEM
- flush_id_o  out  1  load bubble into IF/ID
- flush_ex_o  out  1  load bubble into ID/EX
- bubble_wb_o  out  1  load bubble into MEM/WB
- mem_timeout_o  out  1  sticky DRAM timeout flag
- stall_cnt_o  out  CNT_W  cycles with stall_if_o=1, saturating

Behaviour:
- States: RUN, MEM_WAIT, ABORT. Wait counter wcnt is $clog2(MEM_TIMEOUT)+1 bits.
- Reset (rst_n low, asynchronous):
  - state=RUN, wcnt=0, mem_timeout_o=0, stall_cnt_o=0.
  - All combinational control outputs are forced to 0 while rst_n is low.
- load_use = rf_we_ex_i && wd_sel_ex_i==WD_SEL_DRAM && wr_ex_i!=0 && ((rs1_used_id_i && rs1_id_i==wr_ex_i) || (rs2_used_id_i && rs2_id_i==wr_ex_i)).
- mem_stall = dram_req_o && !dram_ready_i.
- dram_req_o = mem_req_mem_i in RUN; 1 in MEM_WAIT; 0 in ABORT.
- Priority per cycle: mem_stall, then branch, then load_use.
- mem_stall active:
  - stall_if_o, stall_id_o, stall_ex_o and bubble_wb_o are 1.
  - All flushes are 0; a branch or load-use in EX is held, not acted on.
- Branch (no mem_stall): flush_id_o=1 and flush_ex_o=1, giving two bubbles. No stalls.
- Load-use (no mem_stall, no branch):
  - stall_if_o=1, stall_id_o=1, flush_ex_o=1.
  - Exactly one bubble; the next cycle the load sits in MEM, so no repeat.
- Branch and load_use together: branch wins, since the dependent instruction is flushed anyway.
- Transitions:
  - RUN → MEM_WAIT when mem_req_mem_i && !dram_ready_i; wcnt←1.
  - RUN stays RUN when mem_req_mem_i && dram_ready_i (zero-wait access, no stall).
  - MEM_WAIT → RUN on dram_ready_i; wcnt←0. The release cycle has no stall; held branch/load-use act in that same cycle.
  - MEM_WAIT stays MEM_WAIT while !dram_ready_i && wcnt<MEM_TIMEOUT; wcnt++.
  - MEM_WAIT → ABORT when !dram_ready_i && wcnt==MEM_TIMEOUT; mem_timeout_o←1.
  - ABORT → RUN unconditionally after one cycle.
- ABORT cycle:
  - dram_req_o=0, bubble_wb_o=1, no stalls.
  - The failed access is dropped: its write-back is suppressed and EX/MEM advances.
- dram_ready_i is ignored in ABORT and in RUN when mem_req_mem_i=0.
- mem_timeout_o clears only on reset.
- stall_cnt_o increments on each clock edge where stall_if_o=1 and saturates at all-ones.
- Reset asserted mid-MEM_WAIT: immediate return to RUN with all outputs 0; the in-flight request is abandoned.

Test Plan:
- Load x5 in EX (rf_we=1, wd_sel=01, wr=5), ID reads rs1=5 → 1 cycle with stall_if/stall_id/flush_ex=1, next cycle all 0; stall_cnt_o=1.
- Same load with wr=0, or rs1_used=0 → no stall, no flush.
- branch_taken_ex_i=1 together with load_use → flush_id=flush_ex=1, stall_if=0, stall_cnt unchanged.
- mem_req=1, dram_ready low 3 cycles then high → dram_req high 4 cycles; stall_if/id/ex and bubble_wb high exactly 3 cycles; state back to RUN; stall_cnt_o=3.
- Branch held during a 2-cycle DRAM wait → no flush while stalled; flush_id/flush_ex=1 on the release cycle.
- MEM_TIMEOUT=4, dram_ready never asserted → 4 MEM_WAIT stall cycles, then ABORT (dram_req=0, bubble_wb=1), mem_timeout_o=1 and stays 1. Reset mid-wait clears everything to 0.
